// File: rtl/spi_adc_pkg.sv
// Shared types and helpers for the SPI ADC sequence model.
// Default table contents and SPI mode edge selection live here.
package spi_adc_pkg;

  typedef enum logic {IDLE, ACTIVE} state_e;

  // Default table entry: (idx+1) * floor((2^data_w - 1) / seq_depth)
  function automatic logic [63:0] default_entry(input int data_w, input int seq_depth,
                                                input int idx);
    logic [63:0] step;
    step = ((64'd1 << data_w) - 64'd1) / 64'(seq_depth);
    return step * 64'(idx + 1);
  endfunction

  // MISO shifts on the SCLK rise when exactly one of CPOL/CPHA is set.
  function automatic bit shift_on_rise(input bit cpol, input bit cpha);
    return cpol ^ cpha;
  endfunction

endpackage

// File: rtl/spi_adc_seq_model_sync.sv
// Two-flop synchroniser with a third flop for edge detection.
// RST_VAL sets the level the whole chain resets to.
module spi_in_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {3{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign dout = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_adc_seq_model.sv
// SPI slave model of a multi-channel ADC serving programmable per-channel
// sample sequences; the address sent in one frame selects the next frame's data.
module spi_adc_seq_model
  import spi_adc_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int FRAME_W   = 16,
  parameter int NUM_CH    = 4,
  parameter int SEQ_DEPTH = 4,
  parameter int ADDR_POS  = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W    = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              load_en,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic [CH_W-1:0]   cur_ch,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              addr_err,
  output logic [15:0]       frame_cnt
);

  localparam int BC_W       = $clog2(FRAME_W + 1);
  localparam bit SHIFT_RISE = shift_on_rise(CPOL, CPHA);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_in_sync #(.RST_VAL(CPOL)) u_sync_sclk (.clk(clk), .rst(rst), .din(sclk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_in_sync #(.RST_VAL(1'b1)) u_sync_cs (.clk(clk), .rst(rst), .din(cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_in_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]    addr_q, addr_d, cur_ch_q, cur_ch_d;
  logic [IDX_W-1:0]   idx_q [NUM_CH];
  logic [IDX_W-1:0]   idx_d [NUM_CH];
  logic [DATA_W-1:0]  tbl_q [NUM_CH][SEQ_DEPTH];
  logic [DATA_W-1:0]  tbl_d [NUM_CH][SEQ_DEPTH];
  logic [15:0]        cnt_q, cnt_d;
  logic               miso_q, miso_d, oe_q, oe_d;
  logic               done_q, done_d, abort_q, abort_d, aerr_q, aerr_d;
  logic               armed_q, armed_d;
  logic [1:0]         sync_ok_q, sync_ok_d;
  logic [FRAME_W-1:0] word;
  logic               shift_edge, sample_edge;

  assign shift_edge  = SHIFT_RISE ? sclk_rise : sclk_fall;
  assign sample_edge = SHIFT_RISE ? sclk_fall : sclk_rise;
  assign word        = FRAME_W'(tbl_q[cur_ch_q][idx_q[cur_ch_q]]);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    cur_ch_d  = cur_ch_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    aerr_d    = 1'b0;
    // cs_n only counts as seen high once the chain holds real pin samples,
    // so a cs_n held low through reset cannot start a frame.
    sync_ok_d = {sync_ok_q[0], 1'b1};
    armed_d   = armed_q | (cs_s & sync_ok_q[1]);
    tbl_d     = tbl_q;
    if (load_en && int'(load_ch) < NUM_CH && int'(load_idx) < SEQ_DEPTH)
      tbl_d[load_ch][load_idx] = load_data;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        oe_d   = 1'b0;
        if (cs_fall && armed_q) begin
          state_d   = ACTIVE;
          oe_d      = 1'b1;
          bit_cnt_d = '0;
          addr_d    = '0;
          // CPHA=0 presents the MSB immediately, so the register holds the rest.
          if (CPHA) begin
            sr_d   = word;
            miso_d = 1'b0;
          end else begin
            sr_d   = word << 1;
            miso_d = word[FRAME_W-1];
          end
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
          if (bit_cnt_q == BC_W'(FRAME_W)) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
            if (int'(idx_q[cur_ch_q]) == SEQ_DEPTH - 1) idx_d[cur_ch_q] = '0;
            else idx_d[cur_ch_q] = idx_q[cur_ch_q] + IDX_W'(1);
            if (int'(addr_q) < NUM_CH) cur_ch_d = addr_q;
            else aerr_d = 1'b1;
          end else begin
            abort_d = 1'b1;
          end
        end else begin
          if (shift_edge) begin
            miso_d = sr_q[FRAME_W-1];
            sr_d   = sr_q << 1;
          end
          if (sample_edge) begin
            for (int k = 0; k < CH_W; k++)
              if (int'(bit_cnt_q) == ADDR_POS + k) addr_d[CH_W-1-k] = mosi_s;
            if (bit_cnt_q != BC_W'(FRAME_W)) bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      cur_ch_q  <= '0;
      cnt_q     <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      aerr_q    <= 1'b0;
      armed_q   <= 1'b0;
      sync_ok_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        idx_q[c] <= '0;
        for (int i = 0; i < SEQ_DEPTH; i++)
          tbl_q[c][i] <= DATA_W'(default_entry(DATA_W, SEQ_DEPTH, i));
      end
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      cur_ch_q  <= cur_ch_d;
      cnt_q     <= cnt_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      aerr_q    <= aerr_d;
      armed_q   <= armed_d;
      sync_ok_q <= sync_ok_d;
      idx_q     <= idx_d;
      tbl_q     <= tbl_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign cur_ch      = cur_ch_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign addr_err    = aerr_q;
  assign frame_cnt   = cnt_q;

endmodule
